conv_mac_engine: RTL and testbench

Parametrised, handshaked multiply-accumulate convolution engine. It sequentially convolves one window of TAPS signed fixed-point pixels with a runtime-loadable coefficient set plus bias, then rounds and saturates to the pixel format. It uses one shared multiplier over TAPS cycles. It sits between the window/line-buffer stage and the result writer, and supersedes the fixed-coefficient 9-tap convolution datapath.

---
 rtl/conv_mac_engine_pkg.sv | 48 ++++
 rtl/conv_mac_engine_if.sv | 34 +++
 rtl/conv_mac_engine_mac_unit.sv | 43 ++++
 rtl/conv_mac_engine.sv | 171 +++++++++++++++++
 tb/tb_conv_mac_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mac_engine_pkg.sv
// Shared types, default widths and the round/saturate helper for the convolution MAC engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_FRAC_W = 16;
  localparam int DEF_TAPS   = 9;

  // Working width for rounding; comfortably wider than any supported ACC_W.
  localparam int RS_W = 128;

  typedef struct packed {
    logic signed [RS_W-1:0] value;
    logic                   sat;
  } rs_t;

  // Round half toward +inf, drop frac_w bits, clamp to a signed data_w range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] v_in,
                                    input int frac_w, input int data_w);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] v;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t r;
    one = {{(RS_W-1){1'b0}}, 1'b1};
    v   = (v_in + (one <<< (frac_w - 1))) >>> frac_w;
    hi  = (one <<< (data_w - 1)) - one;
    lo  = -(one <<< (data_w - 1));
    if (v > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end else begin
      r.value = v;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// Window-in / result-out handshake plus coefficient and bias write port of the MAC engine.
interface conv_mac_engine_if #(
  parameter int DATA_W = conv_pkg::DEF_DATA_W,
  parameter int TAPS   = conv_pkg::DEF_TAPS
);
  localparam int CNT_W = $clog2(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*DATA_W-1:0]   pixel;
  logic                     coef_wr_en;
  logic [CNT_W-1:0]         coef_addr;
  logic [DATA_W-1:0]        coef_wdata;
  logic                     bias_wr_en;
  logic [DATA_W-1:0]        bias_wdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        result;
  logic                     sat_flag;
  logic                     busy;

  modport master (
    output in_valid, pixel, coef_wr_en, coef_addr, coef_wdata,
           bias_wr_en, bias_wdata, out_ready,
    input  in_ready, out_valid, result, sat_flag, busy
  );

  modport slave (
    input  in_valid, pixel, coef_wr_en, coef_addr, coef_wdata,
           bias_wr_en, bias_wdata, out_ready,
    output in_ready, out_valid, result, sat_flag, busy
  );

endinterface

// File: rtl/conv_mac_engine_mac_unit.sv
// Single signed DATA_W x DATA_W multiplier feeding a full-precision ACC_W accumulator.
module mac_unit #(
  parameter int DATA_W = 20,
  parameter int ACC_W  = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  // Product and next accumulator value; clear wins over enable.
  always_comb begin
    prod_s = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    acc_d  = acc_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_mac_engine.sv
// Handshaked TAPS-tap convolution MAC with loadable coefficients and bias.
// Optional RELU_EN macro: negative results are forced to zero after saturation.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int TAPS   = DEF_TAPS
) (
  input  logic           clk,
  input  logic           reset,
  conv_mac_engine_if.slave bus
);

  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = 2*DATA_W + CNT_W;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        tap_q, tap_d;
  logic signed [DATA_W-1:0] pix_q  [TAPS];
  logic signed [DATA_W-1:0] pix_d  [TAPS];
  logic signed [DATA_W-1:0] coef_q [TAPS];
  logic signed [DATA_W-1:0] coef_d [TAPS];
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    sat_q, sat_d;

  logic                    in_ready_s;
  logic                    accept_s;
  logic                    acc_clr_s;
  logic                    acc_en_s;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [RS_W-1:0]  v_in_s;
  rs_t                     rs_s;
  logic                    unused_s;

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .a     (pix_q[tap_q]),
    .b     (coef_q[tap_q]),
    .acc   (acc_s)
  );

  // Next-state, bank writes, window latch and output staging.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    pix_d      = pix_q;
    coef_d     = coef_q;
    bias_d     = bias_q;
    result_d   = result_q;
    sat_d      = sat_q;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    acc_clr_s  = 1'b0;
    acc_en_s   = 1'b0;
    v_in_s     = RS_W'(acc_s) + (RS_W'(bias_q) <<< FRAC_W);
    rs_s       = round_sat(v_in_s, FRAC_W, DATA_W);

    case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
        // Writes land on the accept edge too, so the new window sees them.
        if (bus.coef_wr_en && (int'(bus.coef_addr) < TAPS)) begin
          coef_d[bus.coef_addr] = bus.coef_wdata;
        end else begin
          coef_d = coef_q;
        end
        if (bus.bias_wr_en) begin
          bias_d = bus.bias_wdata;
        end else begin
          bias_d = bias_q;
        end
        if (bus.in_valid) begin
          accept_s = 1'b1;
          state_d  = MAC;
        end else begin
          state_d  = IDLE;
        end
      end
      MAC: begin
        acc_en_s = 1'b1;
        if (tap_q == CNT_W'(TAPS - 1)) begin
          tap_d   = {CNT_W{1'b0}};
          state_d = FINAL;
        end else begin
          tap_d   = tap_q + CNT_W'(1);
          state_d = MAC;
        end
      end
      FINAL: begin
        sat_d   = rs_s.sat;
        state_d = OUT;
`ifdef RELU_EN
        if (rs_s.value[RS_W-1]) begin
          result_d = {DATA_W{1'b0}};
        end else begin
          result_d = rs_s.value[DATA_W-1:0];
        end
`else
        result_d = rs_s.value[DATA_W-1:0];
`endif
      end
      OUT: begin
        in_ready_s = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept_s = 1'b1;
            state_d  = MAC;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s) begin
      acc_clr_s = 1'b1;
      tap_d     = {CNT_W{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        pix_d[i] = bus.pixel[(TAPS-1-i)*DATA_W +: DATA_W];
      end
    end else begin
      acc_clr_s = 1'b0;
    end
  end

  // State, bank and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tap_q    <= {CNT_W{1'b0}};
      bias_q   <= {DATA_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      sat_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        pix_q[i]  <= {DATA_W{1'b0}};
        coef_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      bias_q   <= bias_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      for (int i = 0; i < TAPS; i++) begin
        pix_q[i]  <= pix_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

  assign unused_s      = ^rs_s.value[RS_W-1:DATA_W];
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q == MAC) || (state_q == FINAL);
  assign bus.result    = result_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine with hand-computed Q4.16 results.
module tb_conv_mac_engine;

  localparam int DW = 20;
  localparam int FW = 16;
  localparam int NT = 9;
  localparam int PW = DW * NT;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  conv_mac_engine_if #(.DATA_W(DW), .TAPS(NT)) bus ();

  conv_mac_engine #(.DATA_W(DW), .FRAC_W(FW), .TAPS(NT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [3:0] addr, input logic [DW-1:0] val);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = addr;
    bus.coef_wdata = val;
    step();
    bus.coef_wr_en = 1'b0;
  endtask

  task automatic wr_bias(input logic [DW-1:0] val);
    bus.bias_wr_en = 1'b1;
    bus.bias_wdata = val;
    step();
    bus.bias_wr_en = 1'b0;
  endtask

  task automatic set_coefs(input logic [DW-1:0] val);
    for (int i = 0; i < NT; i++) begin
      wr_coef(4'(i), val);
    end
  endtask

  task automatic start(input logic [PW-1:0] pix);
    bus.pixel    = pix;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; lat counts cycles after the accept edge.
  task automatic wait_out(output logic [DW-1:0] res, output logic sat, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    res = bus.result;
    sat = bus.sat_flag;
    if (bus.out_ready) step();
  endtask

  task automatic run(input string tag, input logic [PW-1:0] pix,
                     input logic [DW-1:0] exp_res, input logic exp_sat);
    logic [DW-1:0] res;
    logic          sat;
    int            lat;
    start(pix);
    wait_out(res, sat, lat);
    check({tag, "_result"}, 64'(res), 64'(exp_res));
    check({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    check({tag, "_latency"}, 64'(lat), 64'd10);
  endtask

  function automatic logic [PW-1:0] pix_all(input logic [DW-1:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < NT; i++) p[i*DW +: DW] = v;
    return p;
  endfunction

  function automatic logic [PW-1:0] pix_t01(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    p[PW-1 -: DW]    = v0;
    p[PW-DW-1 -: DW] = v1;
    return p;
  endfunction

  initial begin
    logic [DW-1:0] res;
    logic          sat;
    int            lat;
    int            seen;

    bus.in_valid   = 1'b0;
    bus.pixel      = {PW{1'b0}};
    bus.coef_wr_en = 1'b0;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 20'h00000;
    bus.bias_wr_en = 1'b0;
    bus.bias_wdata = 20'h00000;
    bus.out_ready  = 1'b1;
    reset          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_sat", 64'(bus.sat_flag), 64'd0);
    reset = 1'b1;
    step();

    // 9 x 0.5 = 4.5 fits; 9 x 1.0 = 9.0 exceeds the Q4.16 range and clamps.
    set_coefs(20'h10000);
    run("half", pix_all(20'h08000), 20'h48000, 1'b0);
    run("one", pix_all(20'h10000), 20'h7FFFF, 1'b1);

    set_coefs(20'h70000);
    run("pos_sat", pix_all(20'h70000), 20'h7FFFF, 1'b1);
    set_coefs(20'h90000);
`ifdef RELU_EN
    run("neg_sat", pix_all(20'h70000), 20'h00000, 1'b1);
`else
    run("neg_sat", pix_all(20'h70000), 20'h80000, 1'b1);
`endif

    set_coefs(20'h00000);
    wr_coef(4'd0, 20'h08000);
    run("round_up", pix_t01(20'h00001, 20'h00000), 20'h00001, 1'b0);
    run("round_neg_half", pix_t01(20'hFFFFF, 20'h00000), 20'h00000, 1'b0);

    wr_coef(4'd0, 20'h10000);
`ifdef RELU_EN
    run("neg_one", pix_t01(20'hF0000, 20'h00000), 20'h00000, 1'b0);
`else
    run("neg_one", pix_t01(20'hF0000, 20'h00000), 20'hF0000, 1'b0);
`endif
    wr_bias(20'h18000);
    run("bias", pix_t01(20'hF0000, 20'h00000), 20'h08000, 1'b0);
    wr_bias(20'h00000);

    // Out-of-range address must not touch the bank.
    wr_coef(4'd9, 20'h70000);
    run("addr_oob", pix_all(20'h10000), 20'h10000, 1'b0);

    // Write coincident with accept is used by that window.
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 20'h20000;
    start(pix_t01(20'h10000, 20'h00000));
    bus.coef_wr_en = 1'b0;
    wait_out(res, sat, lat);
    check("wr_accept_result", 64'(res), 64'h20000);
    wr_coef(4'd0, 20'h10000);

    // Write issued during MAC is dropped, now and for later windows.
    start(pix_t01(20'h10000, 20'h10000));
    wr_coef(4'd1, 20'h10000);
    wait_out(res, sat, lat);
    check("mac_wr_now", 64'(res), 64'h10000);
    run("mac_wr_later", pix_t01(20'h10000, 20'h10000), 20'h10000, 1'b0);

    // Backpressure with a second window waiting.
    bus.out_ready = 1'b0;
    start(pix_t01(20'h30000, 20'h00000));
    wait_out(res, sat, lat);
    check("bp_a_result", 64'(res), 64'h30000);
    bus.pixel    = pix_t01(20'h20000, 20'h00000);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_result", 64'(bus.result), 64'h30000);
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_b_busy", 64'(bus.busy), 64'd1);
    check("bp_b_out_valid", 64'(bus.out_valid), 64'd0);
    wait_out(res, sat, lat);
    check("bp_b_result", 64'(res), 64'h20000);
    check("bp_b_latency", 64'(lat), 64'd10);

    // Reset in the middle of MAC discards the window and clears the bank.
    start(pix_t01(20'h10000, 20'h00000));
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("mid_rst_no_out", 64'(seen), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    run("post_rst_cleared", pix_t01(20'h10000, 20'h00000), 20'h00000, 1'b0);
    wr_coef(4'd0, 20'h10000);
    run("post_rst_reload", pix_t01(20'h10000, 20'h00000), 20'h10000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
